// File: rtl/exu_issue_ctrl.sv
// Execute-stage issue controller: accepts one decoded op at a time, captures
// single-cycle ALU/CSR results, sequences the multi-cycle unit under a watchdog,
// holds the result for the memory stage and halts on ebreak or watchdog expiry.
// Optional build macro: EXU_PERF_CNT_EN adds issue / multi-cycle stall counters.

`ifndef XLEN
`define XLEN 64
`endif

module exu_issue_ctrl #(
    parameter int unsigned XLEN          = `XLEN,
    parameter int unsigned MC_MAX_CYCLES = 64,
    parameter int unsigned CNT_W         = 7
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    output logic            id_ready,
    input  logic            id_multicycle,
    input  logic            id_ebreak,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] csr_result,
    input  logic            csr_result_valid,
    output logic            mc_start,
    output logic            mc_kill,
    input  logic            mc_done,
    input  logic [XLEN-1:0] mc_result,
    input  logic            flush,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [XLEN-1:0] ex_result,
    output logic [XLEN-1:0] ex_csr_wdata,
    output logic            ex_csr_wen,
`ifdef EXU_PERF_CNT_EN
    output logic [63:0]     perf_issue_cnt,
    output logic [63:0]     perf_mc_stall_cnt,
`endif
    output logic            halt,
    output logic            mc_timeout
);

    typedef enum logic [1:0] {StIdle, StWaitMc, StHold, StHalt} state_e;

    // cnt_q holds the number of WAIT_MC cycles already completed, so the
    // MC_MAX_CYCLES-th cycle after mc_start sees cnt_q == MC_MAX_CYCLES-1.
    localparam logic [CNT_W-1:0] CntLimit = CNT_W'(MC_MAX_CYCLES - 1);
    localparam logic [CNT_W-1:0] CntSat   = '1;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic              wen_q, wen_d;
    logic              timeout_q, timeout_d;
    logic              accept;
    logic              limit_hit;

    // Handshake and multi-cycle unit control, all combinational.
    always_comb begin
        id_ready = 1'b0;
        unique case (state_q)
            StIdle:  id_ready = !flush;
            StHold:  id_ready = !flush && ex_ready;
            default: id_ready = 1'b0;
        endcase
        accept    = id_valid && id_ready;
        mc_start  = accept && id_multicycle && !id_ebreak;
        limit_hit = (cnt_q >= CntLimit);
        // mc_done in the limit cycle wins over the watchdog; flush always kills.
        mc_kill   = (state_q == StWaitMc) && (flush || (limit_hit && !mc_done));
    end

    // Next-state and held-result update.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        wdata_d   = wdata_q;
        wen_d     = wen_q;
        timeout_d = timeout_q;
        unique case (state_q)
            StIdle, StHold: begin
                if (flush) begin
                    state_d = StIdle;
                    wen_d   = 1'b0;
                end else if (accept) begin
                    if (id_ebreak) begin
                        state_d = StHalt;
                        wen_d   = 1'b0;
                    end else if (id_multicycle) begin
                        state_d = StWaitMc;
                        cnt_d   = '0;
                        wen_d   = 1'b0;
                    end else begin
                        // Back-to-back from HOLD overwrites the old result here.
                        state_d  = StHold;
                        result_d = alu_result;
                        wdata_d  = csr_result;
                        wen_d    = csr_result_valid;
                    end
                end else if ((state_q == StHold) && ex_ready) begin
                    state_d = StIdle;
                    wen_d   = 1'b0;
                end
            end
            StWaitMc: begin
                if (cnt_q != CntSat) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (flush) begin
                    state_d = StIdle;
                    wen_d   = 1'b0;
                end else if (mc_done) begin
                    state_d  = StHold;
                    result_d = mc_result;
                    wen_d    = 1'b0;
                end else if (limit_hit) begin
                    state_d   = StHalt;
                    timeout_d = 1'b1;
                end
            end
            default: begin
                state_d = StHalt;
            end
        endcase
    end

    // State and result registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            result_q  <= '0;
            wdata_q   <= '0;
            wen_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            wdata_q   <= wdata_d;
            wen_q     <= wen_d;
            timeout_q <= timeout_d;
        end
    end

    assign ex_valid     = (state_q == StHold);
    assign halt         = (state_q == StHalt);
    assign ex_result    = result_q;
    assign ex_csr_wdata = wdata_q;
    assign ex_csr_wen   = wen_q;
    assign mc_timeout   = timeout_q;

`ifdef EXU_PERF_CNT_EN
    logic [63:0] issue_cnt_q;
    logic [63:0] stall_cnt_q;

    // Performance counters; both freeze naturally in HALT (no accepts, no WAIT_MC).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            issue_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (accept) begin
                issue_cnt_q <= issue_cnt_q + 64'd1;
            end
            if (state_q == StWaitMc) begin
                stall_cnt_q <= stall_cnt_q + 64'd1;
            end
        end
    end

    assign perf_issue_cnt    = issue_cnt_q;
    assign perf_mc_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_exu_issue_ctrl.sv
// Self-checking bench for exu_issue_ctrl: directed scenarios with literal
// expectations plus randomized traffic, all checked every cycle against a
// behavioural model of the execute stage.

module tb_exu_issue_ctrl;

    localparam int unsigned XLEN = 64;
    localparam int unsigned MAXC = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n, id_valid, id_multicycle, id_ebreak, csr_result_valid;
    logic            mc_done, flush, ex_ready;
    logic [XLEN-1:0] alu_result, csr_result, mc_result;
    logic            id_ready, mc_start, mc_kill, ex_valid, ex_csr_wen, halt, mc_timeout;
    logic [XLEN-1:0] ex_result, ex_csr_wdata;
`ifdef EXU_PERF_CNT_EN
    logic [63:0]     perf_issue_cnt, perf_mc_stall_cnt;
`endif

    exu_issue_ctrl #(
        .XLEN         (XLEN),
        .MC_MAX_CYCLES(MAXC),
        .CNT_W        (7)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_valid        (id_valid),
        .id_ready        (id_ready),
        .id_multicycle   (id_multicycle),
        .id_ebreak       (id_ebreak),
        .alu_result      (alu_result),
        .csr_result      (csr_result),
        .csr_result_valid(csr_result_valid),
        .mc_start        (mc_start),
        .mc_kill         (mc_kill),
        .mc_done         (mc_done),
        .mc_result       (mc_result),
        .flush           (flush),
        .ex_valid        (ex_valid),
        .ex_ready        (ex_ready),
        .ex_result       (ex_result),
        .ex_csr_wdata    (ex_csr_wdata),
        .ex_csr_wen      (ex_csr_wen),
`ifdef EXU_PERF_CNT_EN
        .perf_issue_cnt   (perf_issue_cnt),
        .perf_mc_stall_cnt(perf_mc_stall_cnt),
`endif
        .halt            (halt),
        .mc_timeout      (mc_timeout)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: what the stage is doing, not how it is encoded.
    bit              m_halted, m_busy, m_have, m_wen, m_to;
    int              m_age;     // which cycle after mc_start the current one is
    logic [XLEN-1:0] m_res, m_wdata;
    longint unsigned m_issue, m_stall;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_halted = 0; m_busy = 0; m_have = 0; m_wen = 0; m_to = 0; m_age = 0;
        m_res = '0; m_wdata = '0; m_issue = 0; m_stall = 0;
    endtask

    task automatic idle_in();
        id_valid = 0; id_multicycle = 0; id_ebreak = 0; csr_result_valid = 0;
        mc_done = 0; flush = 0; ex_ready = 1;
    endtask

    // Compare the DUT with the model for the inputs now applied, advance the
    // model, then move to just after the next rising edge.
    task automatic tick();
        bit rdy, acc, kill;
        #1;
        rdy  = !flush && !m_halted && !m_busy && (!m_have || ex_ready);
        acc  = id_valid && rdy;
        kill = m_busy && (flush || (m_age >= MAXC && !mc_done));
        chk("id_ready", id_ready, rdy);
        chk("mc_start", mc_start, acc && id_multicycle && !id_ebreak);
        chk("mc_kill", mc_kill, kill);
        chk("ex_valid", ex_valid, m_have);
        chk("ex_result", ex_result, m_res);
        chk("ex_csr_wdata", ex_csr_wdata, m_wdata);
        chk("ex_csr_wen", ex_csr_wen, m_have && m_wen);
        chk("halt", halt, m_halted);
        chk("mc_timeout", mc_timeout, m_to);
`ifdef EXU_PERF_CNT_EN
        chk("perf_issue_cnt", perf_issue_cnt, m_issue);
        chk("perf_mc_stall_cnt", perf_mc_stall_cnt, m_stall);
`endif
        if (!rst_n) begin
            model_reset();
        end else if (!m_halted) begin
            if (acc) m_issue++;
            if (m_busy) m_stall++;
            if (flush) begin
                m_busy = 0; m_have = 0; m_wen = 0;
            end else if (m_busy) begin
                if (mc_done) begin
                    m_busy = 0; m_have = 1; m_res = mc_result; m_wen = 0;
                end else if (m_age >= MAXC) begin
                    m_busy = 0; m_halted = 1; m_to = 1;
                end else begin
                    m_age++;
                end
            end else if (acc) begin
                if (id_ebreak) begin
                    m_halted = 1; m_have = 0; m_wen = 0;
                end else if (id_multicycle) begin
                    m_busy = 1; m_have = 0; m_wen = 0; m_age = 1;
                end else begin
                    m_have = 1; m_res = alu_result; m_wdata = csr_result;
                    m_wen = csr_result_valid;
                end
            end else if (m_have && ex_ready) begin
                m_have = 0; m_wen = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    int stuck;

    initial begin
        rst_n = 0;
        idle_in();
        alu_result = '0; csr_result = '0; mc_result = '0;
        model_reset();
        @(posedge clk);
        #1;

        // Reset state.
        tick();
        chk("rst_ex_valid", ex_valid, 0);
        chk("rst_halt", halt, 0);
        chk("rst_ex_result", ex_result, 0);
        rst_n = 1;

        // Single-cycle op, latency 1, then back to idle.
        id_valid = 1; alu_result = 64'h1234;
        tick();
        id_valid = 0;
        chk("t1_ex_valid", ex_valid, 1);
        chk("t1_ex_result", ex_result, 64'h1234);
        tick();
        chk("t1_back_idle", ex_valid, 0);

        // Three back-to-back single-cycle ops.
        for (int i = 1; i <= 3; i++) begin
            id_valid = 1; alu_result = 64'(i);
            #1;
            chk("t2_id_ready", id_ready, 1);
            tick();
            chk("t2_ex_valid", ex_valid, 1);
            chk("t2_ex_result", ex_result, 64'(i));
        end
        id_valid = 0;
        tick();

        // Multi-cycle op, done 5 cycles after start, downstream stalls 3 cycles.
        id_valid = 1; id_multicycle = 1;
        #1;
        chk("t3_mc_start", mc_start, 1);
        tick();
        id_valid = 0; id_multicycle = 0;
        repeat (4) begin
            chk("t3_busy_ready", id_ready, 0);
            tick();
        end
        mc_done = 1; mc_result = 64'hDEAD;
        tick();
        mc_done = 0; ex_ready = 0;
        repeat (3) begin
            chk("t3_ex_valid", ex_valid, 1);
            chk("t3_ex_result", ex_result, 64'hDEAD);
            chk("t3_ex_csr_wen", ex_csr_wen, 0);
            tick();
        end
        ex_ready = 1;
        tick();

        // Watchdog: no mc_done, kill on the 64th cycle after start.
        id_valid = 1; id_multicycle = 1;
        tick();
        id_valid = 0; id_multicycle = 0;
        for (int k = 1; k <= int'(MAXC); k++) begin
            #1;
            chk("t4_mc_kill", mc_kill, 64'(k == int'(MAXC)));
            tick();
        end
        chk("t4_halt", halt, 1);
        chk("t4_timeout", mc_timeout, 1);
        id_valid = 1; flush = 1;
        repeat (3) begin
            #1;
            chk("t4_id_ready", id_ready, 0);
            tick();
            chk("t4_halt_sticky", halt, 1);
        end
        idle_in();
        rst_n = 0;
        tick();
        rst_n = 1;
        chk("t4_timeout_clr", mc_timeout, 0);

        // Flush two cycles into WAIT_MC with a coincident late mc_done.
        id_valid = 1; id_multicycle = 1;
        tick();
        id_valid = 0; id_multicycle = 0;
        tick();
        flush = 1; mc_done = 1; mc_result = 64'hBEEF;
        #1;
        chk("t5_mc_kill", mc_kill, 1);
        tick();
        flush = 0; mc_done = 0;
        chk("t5_ex_valid", ex_valid, 0);
        #1;
        chk("t5_id_ready", id_ready, 1);
        id_valid = 1; alu_result = 64'h55;
        tick();
        id_valid = 0;
        chk("t5_next_op", ex_result, 64'h55);

        // ebreak with a CSR write pending.
        id_valid = 1; id_ebreak = 1; csr_result_valid = 1; csr_result = 64'h77;
        tick();
        idle_in();
        chk("t6_halt", halt, 1);
        chk("t6_ex_valid", ex_valid, 0);
        chk("t6_ex_csr_wen", ex_csr_wen, 0);
        flush = 1; id_valid = 1;
        tick();
        chk("t6_halt_hold", halt, 1);
        chk("t6_id_ready", id_ready, 0);
        idle_in();
        rst_n = 0;
        tick();
        rst_n = 1;
        chk("t6_halt_clr", halt, 0);

        // Randomized traffic.
        stuck = 0;
        for (int c = 0; c < 4000; c++) begin
            stuck            = m_halted ? stuck + 1 : 0;
            rst_n            = (stuck > 8) ? 1'b0 : ($urandom_range(0, 199) != 0);
            id_valid         = ($urandom_range(0, 9) < 6);
            id_multicycle    = ($urandom_range(0, 9) < 3);
            id_ebreak        = ($urandom_range(0, 59) == 0);
            alu_result       = {$urandom, $urandom};
            csr_result       = {$urandom, $urandom};
            csr_result_valid = $urandom_range(0, 1) == 1;
            mc_result        = {$urandom, $urandom};
            mc_done          = ($urandom_range(0, 5) == 0);
            flush            = ($urandom_range(0, 15) == 0);
            ex_ready         = ($urandom_range(0, 9) < 7);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/exu_issue_ctrl.md
Name: exu_issue_ctrl

Overview:
- Execute-stage sequencer between decode and memory stage.
- Accepts one decoded instruction at a time over valid/ready.
- Single-cycle ops: captures the combinational ALU/CSR results.
- Multi-cycle ops: launches and tracks the multi-cycle unit (mul/div), with a watchdog. Holds the result until the downstream stage takes it; halts the core on ebreak.

Parameters:
- XLEN, `XLEN (64): data width.
- MC_MAX_CYCLES, 64: watchdog limit for one multi-cycle op, in cycles after mc_start; must be ≥2.
- CNT_W, 7: watchdog counter width; must satisfy 2^CNT_W > MC_MAX_CYCLES.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- id_valid  in  1  decode presents an instruction.
- id_ready  out  1  controller accepts this cycle.
- id_multicycle  in  1  op executes on the multi-cycle unit.
- id_ebreak  in  1  op is ebreak.
- alu_result  in  XLEN  combinational ALU result, valid while id_valid.
- csr_result  in  XLEN  combinational CSR new value.
- csr_result_valid  in  1  CSR write required.
- mc_start  out  1  launch multi-cycle unit; operands valid this cycle.
- mc_kill  out  1  abort in-flight multi-cycle op.
- mc_done  in  1  multi-cycle result valid (1-cycle pulse).
- mc_result  in  XLEN  multi-cycle result.
- flush  in  1  squash execute stage.
- ex_valid  out  1  result held for memory stage.
- ex_ready  in  1  memory stage accepts.
- ex_result  out  XLEN  held result.
- ex_csr_wdata  out  XLEN  held CSR write data.
- ex_csr_wen  out  1  CSR write enable; qualified by ex_valid.
- halt  out  1  core halted (ebreak or watchdog).
- mc_timeout  out  1  sticky watchdog error.

Behaviour:
- States: IDLE, WAIT_MC, HOLD, HALT.
- Reset (rst_n=0 at a clock edge):
  - State goes to IDLE.
  - All outputs and registers go to 0: ex_valid, ex_result, ex_csr_wdata, ex_csr_wen, halt, mc_timeout, counter.
  - Reset mid-operation drops any in-flight op with no mc_kill; the multi-cycle unit is reset by the same rst_n.
- id_ready = !flush & (state==IDLE | (state==HOLD & ex_ready)). It is 0 in WAIT_MC and HALT.
- accept = id_valid & id_ready.
- mc_start = accept & id_multicycle & !id_ebreak. It is combinational, exactly one cycle per op.
- On accept:
  - id_ebreak: go to HALT; halt=1 from the next cycle; ex_valid=0; no result captured.
  - id_multicycle: go to WAIT_MC; counter is cleared; ex_valid=0.
  - Otherwise: ex_result<=alu_result, ex_csr_wdata<=csr_result, ex_csr_wen<=csr_result_valid. Go to HOLD with ex_valid=1 next cycle (latency 1).
- HOLD with ex_ready=1 and no accept: go to IDLE, ex_valid=0.
- HOLD with ex_ready=1 and accept: back-to-back. The new result replaces the old in the same edge, so ex_valid stays 1 and a single-cycle op gets 1 instruction per cycle. A multi-cycle accept goes to WAIT_MC.
- HOLD with ex_ready=0: all held outputs stable.
- WAIT_MC:
  - Counter increments each cycle.
  - mc_done=1: ex_result<=mc_result, ex_csr_wen<=0; go to HOLD.
  - Counter reaching MC_MAX_CYCLES without mc_done: mc_kill=1 for one cycle, mc_timeout<=1, go to HALT.
  - mc_done in the same cycle as the limit: mc_done wins.
- mc_done outside WAIT_MC is ignored. That includes the accept cycle itself; the earliest valid mc_done is 1 cycle after mc_start.
- flush (priority below reset, above everything else), in IDLE/HOLD/WAIT_MC:
  - Next state IDLE, ex_valid=0, ex_csr_wen=0, no accept.
  - In WAIT_MC, mc_kill=1 that cycle, and a coincident mc_done is discarded.
- flush in HALT has no effect.
- HALT exits only via reset. All handshakes stay deasserted.
- Counter saturates and never wraps.

Optional Feature:
- Macro: EXU_PERF_CNT_EN.
- Defined: adds outputs perf_issue_cnt[63:0] and perf_mc_stall_cnt[63:0], both reset to 0.
  - perf_issue_cnt increments on each accept, ebreak included.
  - perf_mc_stall_cnt increments on each cycle spent in WAIT_MC.
  - Both wrap modulo 2^64 and both freeze in HALT.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset then single-cycle op, alu_result=0x1234, ex_ready=1: ex_valid=1 one cycle after accept with ex_result=0x1234; returns to IDLE the next cycle.
- Three back-to-back single-cycle ops (0x1,0x2,0x3), ex_ready=1 always: id_ready stays 1; ex_result sequence 0x1,0x2,0x3 on consecutive cycles; ex_valid continuous.
- Multi-cycle op with mc_done 5 cycles after mc_start, mc_result=0xDEAD, ex_ready=0 for 3 cycles afterwards: mc_start exactly 1 pulse; id_ready=0 throughout; ex_result=0xDEAD stable while stalled; ex_csr_wen=0.
- Multi-cycle op with no mc_done, MC_MAX_CYCLES=64: after 64 cycles mc_kill pulses once; mc_timeout=1 and halt=1 sticky; id_ready=0 until rst_n=0.
- flush asserted 2 cycles into WAIT_MC, coincident with a late mc_done: mc_kill=1; ex_valid stays 0; IDLE the next cycle; the following op accepted normally.
- ebreak accept while csr_result_valid=1: halt=1 the next cycle; ex_valid=0, ex_csr_wen=0; flush and id_valid are ignored afterwards; rst_n=0 clears halt.
